apb_reg_slave: RTL and testbench
================================

# apb_reg_slave

APB slave register file sitting directly downstream of the AHB-to-APB bridge. It consumes the bridge's PSEL/PENABLE/PADDR/PWRITE/PWDATA and returns PRDATA (which the bridge forwards to HRDATA), plus PREADY and PSLVERR. It holds NUM_REGS word registers and inserts a fixed number of wait states per transfer. Out-of-range or misaligned accesses are flagged with PSLVERR.

## Interface
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, register/data width
- NUM_REGS, 16, number of word registers; power of two, ≥2
- WAIT_CYCLES, 2, wait states per transfer; used only with APB_SLV_WAIT_EN
- HCLK  in  1  clock; all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PADDR  in  ADDR_WIDTH  byte address
- PWRITE  in  1  1 = write, 0 = read
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data, valid while PREADY=1
- PREADY  out  1  transfer completes at the end of a cycle with PSEL&PENABLE&PREADY
- PSLVERR  out  1  error response, valid while PREADY=1

## Operation
- Index = PADDR[log2(NUM_REGS)+1:2]. Address error if PADDR ≥ NUM_REGS*4 or PADDR[1:0]≠0.
- FSM states: IDLE, WAIT, READY.
- IDLE: on an edge sampling PSEL=1, PENABLE=0 (setup), capture addr_q, write_q and err_q. Then:
  - go to WAIT with cnt=WAIT_CYCLES if WAIT_CYCLES>0;
  - otherwise go to READY.
  - PSEL&PENABLE seen in IDLE (no preceding setup) is ignored; stay in IDLE.
- WAIT: cnt decrements each edge. On the edge where cnt==1, go to READY. If PSEL=0 is sampled, go to IDLE with no commit.
- READY: PREADY=1. PSLVERR=err_q. PRDATA=reg[addr_q] when the access is a read with no error, else 0.
- At the edge ending READY with PSEL&PENABLE:
  - write with no error: reg[addr_q]←PWDATA, sampled at this edge;
  - error: no register change;
  - go to IDLE (a back-to-back setup is detected from IDLE on the next edge).
- At the edge ending READY with PSEL=0: go to IDLE, no commit.
- PRDATA, PREADY and PSLVERR are registered. The values for READY are loaded on the edge entering READY. They are all 0 in every other state.
- Register values are taken on entry to READY, so a write is visible to any read whose READY starts after the write's commit edge.

## Timing
- Reset (synchronous, HRESET=1 at an edge): state=IDLE, cnt=0, all registers 0, PRDATA=0, PREADY=0, PSLVERR=0. A transfer in flight is aborted with no commit.
- Zero-wait transfer: 2 cycles (setup, access). PREADY is high in the access cycle.
- N waits: N+2 cycles. PREADY is low for the first N access cycles.
- Back-to-back transfers: setup directly follows the completing access cycle; no idle cycle is required.
- PADDR, PWRITE and PWDATA changing during WAIT do not affect the transfer. Address and control come from the setup capture; data is sampled at the commit edge.

## Configuration
- APB_SLV_WAIT_EN defined:
  - WAIT state and counter are compiled in;
  - WAIT_CYCLES is honoured (0 is legal and behaves as zero-wait).
- APB_SLV_WAIT_EN undefined:
  - WAIT state and counter are removed and WAIT_CYCLES is ignored;
  - IDLE goes straight to READY, so every transfer is 2 cycles.

## Test plan
- Reset: assert HRESET for 2 cycles mid-transfer, then read PADDR=0x0 → PRDATA=0, PSLVERR=0, no stale commit.
- Write then read (WAIT_CYCLES=2, macro on): write 0xDEADBEEF to 0x8, then read 0x8 → PREADY low 2 access cycles then high; PRDATA=0xDEADBEEF; each transfer 4 cycles.
- Back-to-back (macro off): write 0x11 to 0x0, immediately write 0x22 to 0x4, then read both → 0x11 and 0x22, each transfer 2 cycles, no idle gap.
- Errors: write 0xFFFF to 0x40 (NUM_REGS=16), then read 0x6 → PSLVERR=1 and PRDATA=0 on both; no register changed.
- Abort: drop PSEL during WAIT of a write of 0xAA to 0xC → reg 3 stays 0, FSM back in IDLE, next read of 0xC returns 0.
- Protocol violation: PSEL=1, PENABLE=1 with no prior setup → PREADY stays 0 and no write occurs.

Source files
------------

// File: rtl/apb_reg_slave.sv
// -----------------------------------------------------------------------------
// apb_reg_slave
//
// APB register-file slave fed by an AHB-to-APB bridge. Holds NUM_REGS word
// registers, optionally inserts WAIT_CYCLES wait states per transfer, and
// flags out-of-range or misaligned accesses with PSLVERR.
//
// Optional feature macro: APB_SLV_WAIT_EN
//   defined   : WAIT state and wait counter compiled in, WAIT_CYCLES honoured
//   undefined : every transfer completes in two cycles (setup + access)
//
// Ports:
//   HCLK     in   clock, all logic on the rising edge
//   HRESET   in   synchronous active-high reset
//   PSEL     in   slave select
//   PENABLE  in   access phase
//   PADDR    in   byte address [ADDR_WIDTH]
//   PWRITE   in   1 = write, 0 = read
//   PWDATA   in   write data [DATA_WIDTH]
//   PRDATA   out  registered read data, valid while PREADY=1
//   PREADY   out  registered transfer-complete flag
//   PSLVERR  out  registered error response, valid while PREADY=1
// -----------------------------------------------------------------------------
module apb_reg_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      addr_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Decode of the live bus, only meaningful during a setup cycle.
    logic [IDX_W-1:0]      setup_idx;
    logic                  setup_err;

    // Attributes of the access whose READY outputs are loaded this edge.
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_err;
    logic                  rd_write;

    logic                  capture;
    logic                  load_ready;
    logic                  commit;

    assign setup_idx = PADDR[IDX_W+1:2];
    assign setup_err = (PADDR >= ADDR_LIMIT) || (PADDR[1:0] != 2'b00);

`ifdef APB_SLV_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        load_ready = 1'b0;
        commit     = 1'b0;
        rd_idx     = addr_q;
        rd_err     = err_q;
        rd_write   = write_q;
`ifdef APB_SLV_WAIT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                // PSEL&PENABLE without a preceding setup is ignored here.
                if (PSEL && !PENABLE) begin
                    capture  = 1'b1;
                    // Zero-wait entry into READY loads outputs from the live
                    // decode, because the capture registers update on this edge.
                    rd_idx   = setup_idx;
                    rd_err   = setup_err;
                    rd_write = PWRITE;
`ifdef APB_SLV_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end else begin
                        state_d    = S_READY;
                        load_ready = 1'b1;
                    end
`else
                    state_d    = S_READY;
                    load_ready = 1'b1;
`endif
                end
            end
`ifdef APB_SLV_WAIT_EN
            S_WAIT: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d    = S_READY;
                    load_ready = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            S_READY: begin
                // Every exit from READY returns to IDLE; only a completed
                // error-free write touches the register file.
                state_d = S_IDLE;
                commit  = PSEL && PENABLE && write_q && !err_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            PRDATA  <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q  <= setup_idx;
                write_q <= PWRITE;
                err_q   <= setup_err;
            end
            // Outputs are non-zero only in READY; they drop back to 0 on the
            // edge that leaves it.
            PREADY  <= load_ready;
            PSLVERR <= load_ready && rd_err;
            PRDATA  <= (load_ready && !rd_write && !rd_err) ? regs[rd_idx] : '0;
        end
    end

`ifdef APB_SLV_WAIT_EN
    always_ff @(posedge HCLK) begin
        if (HRESET) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    // NOTE: the register file is architecturally visible state that must read
    // as 0 after reset, so it is reset explicitly rather than left as RAM.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[addr_q] <= PWDATA;
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_reg_slave
//
// Directed self-checking bench for apb_reg_slave with default parameters.
// Expected wait-state count follows the APB_SLV_WAIT_EN build setting.
// -----------------------------------------------------------------------------
module tb_apb_reg_slave;

`ifdef APB_SLV_WAIT_EN
    localparam int EXP_WAITS = 2;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_checks = 0;
    int n_errors = 0;

    apb_reg_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16),
        .WAIT_CYCLES(2)
    ) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .PSEL   (psel),
        .PENABLE(penable),
        .PADDR  (paddr),
        .PWRITE (pwrite),
        .PWDATA (pwdata),
        .PRDATA (prdata),
        .PREADY (pready),
        .PSLVERR(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer starting in the current cycle (called #1 after an
    // edge). Access-phase address/data may differ from the setup values.
    // Leaves the bus idle at the start of the following cycle so a new
    // transfer can begin immediately.
    task automatic xfer_full(input string tag, input logic [31:0] addr, input logic wr,
                             input logic [31:0] wdata, input logic [31:0] acc_addr,
                             input logic [31:0] acc_wdata, input logic [31:0] exp_rd,
                             input logic exp_err);
        int waits;
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        next_cycle();
        penable = 1'b1;
        paddr   = acc_addr;
        pwdata  = acc_wdata;
        waits   = 0;
        while (pready !== 1'b1 && waits < 16) begin
            next_cycle();
            waits++;
        end
        check({tag, "_waits"}, 32'(waits), 32'(EXP_WAITS));
        check({tag, "_prdata"}, prdata, exp_rd);
        check({tag, "_pslverr"}, {31'd0, pslverr}, {31'd0, exp_err});
        next_cycle();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err);
        xfer_full(tag, addr, wr, wdata, addr, wdata, exp_rd, exp_err);
    endtask

    initial begin
        rst     = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        paddr   = '0;
        pwrite  = 1'b0;
        pwdata  = '0;
        repeat (2) next_cycle();
        check("rst_pready",  {31'd0, pready},  32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_prdata",  prdata, 32'd0);
        rst = 1'b0;

        // Reset two cycles into a write to 0x0: nothing may be committed.
        psel = 1'b1; penable = 1'b0; paddr = 32'h0; pwrite = 1'b1; pwdata = 32'h55;
        next_cycle();
        penable = 1'b1;
        rst     = 1'b1;
        next_cycle();
        check("midrst_pready", {31'd0, pready}, 32'd0);
        next_cycle();
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        xfer("midrst_rd0", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Write then read back.
        xfer("wr8", 32'h8, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
        xfer("rd8", 32'h8, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);

        // Back-to-back writes then reads, no idle cycles between transfers.
        xfer("wr0", 32'h0, 1'b1, 32'h11, 32'h0, 1'b0);
        xfer("wr4", 32'h4, 1'b1, 32'h22, 32'h0, 1'b0);
        xfer("rd0", 32'h0, 1'b0, 32'h0, 32'h11, 1'b0);
        xfer("rd4", 32'h4, 1'b0, 32'h0, 32'h22, 1'b0);

        // Errors: first out-of-range address (aliases index 0), misaligned
        // read and write (alias index 1). No register may change.
        xfer("wr40_err", 32'h40, 1'b1, 32'hFFFF, 32'h0, 1'b1);
        xfer("rd6_err",  32'h6,  1'b0, 32'h0,    32'h0, 1'b1);
        xfer("wr6_err",  32'h6,  1'b1, 32'hBAD,  32'h0, 1'b1);
        xfer("rd0_after_err", 32'h0, 1'b0, 32'h0, 32'h11, 1'b0);
        xfer("rd4_after_err", 32'h4, 1'b0, 32'h0, 32'h22, 1'b0);

        // Last valid word; access-phase address and early data changes are
        // ignored, data is taken at the commit edge.
        xfer_full("wr3c", 32'h3C, 1'b1, 32'h12345678, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
        xfer("rd3c", 32'h3C, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
        xfer("rd0_after_3c", 32'h0, 1'b0, 32'h0, 32'h11, 1'b0);

        // Abort: PSEL dropped right after setup of a write of 0xAA to 0xC.
        psel = 1'b1; penable = 1'b0; paddr = 32'hC; pwrite = 1'b1; pwdata = 32'hAA;
        next_cycle();
        psel = 1'b0;
        repeat (3) next_cycle();
        check("abort_pready", {31'd0, pready}, 32'd0);
        xfer("abort_rdc", 32'hC, 1'b0, 32'h0, 32'h0, 1'b0);

        // Protocol violation: access phase with no setup stays ignored.
        psel = 1'b1; penable = 1'b1; paddr = 32'h10; pwrite = 1'b1; pwdata = 32'h99;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check("noset_pready", {31'd0, pready}, 32'd0);
        end
        psel = 1'b0; penable = 1'b0;
        next_cycle();
        xfer("noset_rd10", 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
